// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types and widths for the
// multi-approach traffic light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    AMBER  = 2'd2,
    FLASH  = 2'd3
  } state_t;

  localparam int TW = 8;
  localparam int PW = 2;

endpackage

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: divides clk down to a one-cycle
// tick pulse every TICK_DIV cycles.
module tlc_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic res,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] L_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] L_PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // tick is registered so it is high exactly while r_cnt == TICK_DIV-1
  always_ff @(posedge clk) begin
    if (res) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == L_LAST) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == L_PRE);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tlc_multi.sv
// tlc_multi: N-approach traffic light controller with
// round-robin demand service, gap-out and flash override.
module tlc_multi
  import tlc_pkg::*;
#(
  parameter int N_APPR   = 2,
  parameter int TICK_DIV = 100000000,
  parameter int T_GMIN   = 10,
  parameter int T_GMAX   = 60,
  parameter int T_AMBER  = 3,
  parameter int T_ALLRED = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic [N_APPR-1:0] sns,
  input  logic              flash,
  output logic [N_APPR-1:0] green,
  output logic [N_APPR-1:0] amber,
  output logic [N_APPR-1:0] red,
  output logic [1:0]        cur_phase,
  output logic [2:0]        state_o,
  output logic              tick
);

  localparam logic [N_APPR-1:0] ONE = N_APPR'(1);
  localparam logic [TW-1:0] L_GMIN   = TW'(T_GMIN);
  localparam logic [TW-1:0] L_GMAX   = TW'(T_GMAX);
  localparam logic [TW-1:0] L_AMBER  = TW'(T_AMBER);
  localparam logic [TW-1:0] L_ALLRED = TW'(T_ALLRED);

  logic              w_tick;
  state_t            r_state;
  logic [PW-1:0]     r_phase;
  logic [TW-1:0]     r_timer;
  logic [N_APPR-1:0] r_demand;
  logic [N_APPR-1:0] r_green;
  logic [N_APPR-1:0] r_amber;
  logic [N_APPR-1:0] r_red;
  logic              r_tog;
  logic              r_init;

  logic [TW-1:0]     w_elapsed;
  logic [N_APPR-1:0] w_sel;
  logic              w_conflict;
  logic              w_gap;
  logic [PW-1:0]     w_next;
  int                w_start;
  int                w_idx;
  state_t            w_nstate;
  logic [PW-1:0]     w_nphase;
  logic              w_ntog;
  logic              w_enter_green;
  logic [N_APPR-1:0] w_nsel;
  logic [N_APPR-1:0] w_ngreen;
  logic [N_APPR-1:0] w_namber;

  tlc_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .res  (res),
    .tick (w_tick)
  );

  assign w_elapsed  = (r_timer == '1) ? r_timer : r_timer + 1'b1;
  assign w_sel      = ONE << r_phase;
  assign w_conflict = flash | (|(r_demand & ~w_sel));
  assign w_gap      = ~|(sns & w_sel);

  // Cyclic demand search; before the first green after reset
  // the search includes approach 0 so service starts there.
  always_comb begin
    w_start = r_init ? 0 : int'(r_phase) + 1;
    w_idx   = 0;
    w_next  = PW'(w_start % N_APPR);
    for (int k = N_APPR - 1; k >= 0; k--) begin
      w_idx = (w_start + k) % N_APPR;
      if (|(r_demand & (ONE << w_idx)))
        w_next = PW'(w_idx);
    end
  end

  // Next-state decision, only ever moving on tick cycles
  always_comb begin
    w_nstate = r_state;
    w_nphase = r_phase;
    if (w_tick) begin
      unique case (r_state)
        ALLRED:
          if (w_elapsed >= L_ALLRED) begin
            if (flash) begin
              w_nstate = FLASH;
            end else begin
              w_nstate = GREEN;
              w_nphase = w_next;
            end
          end
        GREEN:
          if (w_elapsed >= L_GMIN && w_conflict &&
              (w_gap || w_elapsed >= L_GMAX))
            w_nstate = AMBER;
        AMBER:
          if (w_elapsed >= L_AMBER) w_nstate = ALLRED;
        FLASH:
          if (!flash) w_nstate = ALLRED;
        default: w_nstate = ALLRED;
      endcase
    end
  end

  // Lamp pattern for the state being entered
  always_comb begin
    w_enter_green = (w_nstate == GREEN) && (r_state != GREEN);
    w_ntog        = r_tog;
    if (w_nstate == FLASH && r_state != FLASH)
      w_ntog = 1'b1;
    else if (r_state == FLASH && w_tick)
      w_ntog = ~r_tog;
    w_nsel   = ONE << w_nphase;
    w_ngreen = (w_nstate == GREEN) ? w_nsel : '0;
    w_namber = '0;
    if (w_nstate == AMBER)
      w_namber = w_nsel;
    else if (w_nstate == FLASH)
      w_namber = {N_APPR{w_ntog}};
  end

  // FSM, timer, demand latch and registered lamps
  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= ALLRED;
      r_phase  <= '0;
      r_timer  <= '0;
      r_demand <= '0;
      r_tog    <= 1'b0;
      r_init   <= 1'b1;
      r_green  <= '0;
      r_amber  <= '0;
      r_red    <= '1;
    end else begin
      r_state <= w_nstate;
      r_phase <= w_nphase;
      r_tog   <= w_ntog;
      if (w_nstate != r_state)
        r_timer <= '0;
      else if (w_tick)
        r_timer <= w_elapsed;
      if (w_enter_green)
        r_init <= 1'b0;
      r_demand <= (r_demand | sns) &
                  ~(w_enter_green ? w_nsel : '0);
      r_green <= w_ngreen;
      r_amber <= w_namber;
      r_red   <= (w_nstate == FLASH) ? '0 :
                 ~(w_ngreen | w_namber);
    end
  end

  assign green     = r_green;
  assign amber     = r_amber;
  assign red       = r_red;
  assign cur_phase = r_phase;
  assign state_o   = {1'b0, r_state};
  assign tick      = w_tick;

endmodule

// File: tb/tb_tlc_multi.sv
// tb_tlc_multi: directed scenarios plus random sensor/flash
// traffic on a 2-approach and a 4-approach controller.
module tb_tlc_multi;

  localparam int TD = 4;

  logic       clk;
  logic       rs2, f2, t2, rs4, f4, t4;
  logic [1:0] s2, g2, a2, rd2, ph2, ph4;
  logic [3:0] s4, g4, a4, rd4;
  logic [2:0] st2, st4;

  int vec, err, cn;
  int tg, ta, tr, tn, tf, tx, k;
  bit ok;

  int       m_st[2], m_ph[2], m_tim[2], m_cnt[2];
  bit       m_tog[2], m_init[2];
  bit [3:0] m_dem[2];

  tlc_multi #(.N_APPR(2), .TICK_DIV(TD)) u2 (
    .clk(clk), .res(rs2), .sns(s2), .flash(f2),
    .green(g2), .amber(a2), .red(rd2),
    .cur_phase(ph2), .state_o(st2), .tick(t2)
  );

  tlc_multi #(.N_APPR(4), .TICK_DIV(TD)) u4 (
    .clk(clk), .res(rs4), .sns(s4), .flash(f4),
    .green(g4), .amber(a4), .red(rd4),
    .cur_phase(ph4), .state_o(st4), .tick(t4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nap(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic bit [3:0] msk(input int i);
    return (i == 0) ? 4'b0011 : 4'b1111;
  endfunction

  function automatic bit hit(input bit [3:0] v, input int b);
    return ((v >> b) & 4'd1) != 4'd0;
  endfunction

  // Reference: states 0 allred, 1 green, 2 amber, 3 flash
  task automatic mstep(input int i, input bit rs,
                       input bit [3:0] sn_in, input bit fl);
    int el, n, nst, pick, s, c, clr;
    bit conf;
    bit [3:0] sn;
    n = nap(i);
    sn = sn_in & msk(i);
    clr = -1;
    if (rs) begin
      m_st[i] = 0; m_ph[i] = 0; m_tim[i] = 0; m_cnt[i] = 0;
      m_tog[i] = 0; m_init[i] = 1; m_dem[i] = 0;
      return;
    end
    if (m_cnt[i] == TD - 1) begin
      el = (m_tim[i] < 255) ? m_tim[i] + 1 : 255;
      nst = m_st[i];
      case (m_st[i])
        0: if (el >= 2) begin
             if (fl) begin
               nst = 3; m_tog[i] = 1;
             end else begin
               s = m_init[i] ? 0 : m_ph[i] + 1;
               pick = -1;
               for (int j = 0; j < n; j++) begin
                 c = (s + j) % n;
                 if (pick < 0 && hit(m_dem[i], c)) pick = c;
               end
               if (pick < 0) pick = s % n;
               nst = 1; m_ph[i] = pick; clr = pick; m_init[i] = 0;
             end
           end
        1: begin
             conf = fl || ((m_dem[i] & msk(i) &
                    ~(4'd1 << m_ph[i])) != 4'd0);
             if (el >= 10 && conf &&
                 (!hit(sn, m_ph[i]) || el >= 60)) nst = 2;
           end
        2: if (el >= 3) nst = 0;
        default: if (!fl) nst = 0; else m_tog[i] = ~m_tog[i];
      endcase
      m_tim[i] = (nst != m_st[i]) ? 0 : el;
      m_st[i] = nst;
    end
    m_cnt[i] = (m_cnt[i] + 1) % TD;
    m_dem[i] = m_dem[i] | sn;
    if (clr >= 0) m_dem[i] = m_dem[i] & ~(4'd1 << clr);
  endtask

  function automatic logic [11:0] mlamp(input int i);
    bit [3:0] g, a, r, one;
    one = 4'd1 << m_ph[i];
    g = (m_st[i] == 1) ? one : 4'd0;
    a = (m_st[i] == 2) ? one :
        (m_st[i] == 3 && m_tog[i]) ? msk(i) : 4'd0;
    r = (m_st[i] == 3) ? 4'd0 : msk(i) & ~(g | a);
    return {g, a, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    mstep(0, rs2, {2'b00, s2}, f2);
    mstep(1, rs4, s4, f4);
    @(posedge clk);
    #1;
    cn++;
    chk("lamps2", {4'(g2), 4'(a2), 4'(rd2)}, mlamp(0));
    chk("phst2", {ph2, st2}, {2'(m_ph[0]), 3'(m_st[0])});
    chk("tick2", t2, m_cnt[0] == TD - 1);
    chk("lamps4", {g4, a4, rd4}, mlamp(1));
    chk("phst4", {ph4, st4}, {2'(m_ph[1]), 3'(m_st[1])});
    chk("tick4", t4, m_cnt[1] == TD - 1);
  endtask

  task automatic wait_st(input int i, input logic [2:0] tgt,
                         input int bound, output int at);
    int n;
    n = 0;
    while (((i == 0) ? st2 : st4) !== tgt && n < bound) begin
      cyc();
      n++;
    end
    chk("wait_state", (i == 0) ? st2 : st4, tgt);
    at = cn;
  endtask

  initial begin
    vec = 0; err = 0; cn = 0;
    rs2 = 1; rs4 = 1; s2 = 0; s4 = 0; f2 = 0; f4 = 0;
    repeat (3) cyc();
    chk("rst_red", rd2, 2'b11);
    chk("rst_green", g2, 2'b00);
    chk("rst_amber", a2, 2'b00);
    chk("rst_state", st2, 3'd0);
    chk("rst_tick", t2, 1'b0);

    rs2 = 0;
    repeat (8) cyc();
    chk("boot_green", g2, 2'b01);
    chk("boot_phase", ph2, 2'd0);

    ok = 1;
    repeat (400) begin
      cyc();
      if (g2 !== 2'b01) ok = 0;
    end
    chk("rest_green", ok, 1'b1);

    rs2 = 1; cyc(); rs2 = 0;
    repeat (8) cyc();
    tg = cn;
    s2 = 2'b11; cyc(); s2 = 2'b01;
    wait_st(0, 3'd2, 400, ta);
    chk("gmax_cycles", ta - tg, 60 * TD);
    wait_st(0, 3'd0, 20, tr);
    chk("amber_cycles", tr - ta, 3 * TD);
    wait_st(0, 3'd1, 20, tn);
    chk("allred_cycles", tn - tr, 2 * TD);
    chk("gmax_next", g2, 2'b10);

    rs2 = 1; s2 = 0; cyc(); rs2 = 0;
    repeat (8) cyc();
    tg = cn;
    s2 = 2'b11; cyc(); s2 = 2'b01;
    repeat (15) cyc();
    s2 = 2'b00;
    wait_st(0, 3'd2, 200, ta);
    chk("gapout_cycles", ta - tg, 10 * TD);

    rs2 = 1; cyc(); rs2 = 0;
    repeat (8) cyc();
    tg = cn;
    f2 = 1;
    wait_st(0, 3'd2, 200, ta);
    chk("fl_amber", ta - tg, 10 * TD);
    wait_st(0, 3'd3, 40, tf);
    chk("fl_entry", tf - ta, 5 * TD);
    chk("fl_amb_on", a2, 2'b11);
    chk("fl_red", rd2, 2'b00);
    chk("fl_green", g2, 2'b00);
    repeat (TD) cyc();
    chk("fl_amb_off", a2, 2'b00);
    repeat (TD) cyc();
    chk("fl_amb_on2", a2, 2'b11);
    f2 = 0;
    wait_st(0, 3'd0, 2 * TD, tx);
    wait_st(0, 3'd1, 3 * TD, tn);
    chk("fl_exit_ar", tn - tx, 2 * TD);
    chk("fl_exit_ph", ph2, 2'd1);
    f2 = 1;
    wait_st(0, 3'd3, 200, tf);
    rs2 = 1; cyc(); rs2 = 0; f2 = 0;
    chk("fl_rst_state", st2, 3'd0);
    chk("fl_rst_red", rd2, 2'b11);
    chk("fl_rst_amber", a2, 2'b00);

    rs4 = 0;
    repeat (8) cyc();
    chk("skip_boot", g4, 4'b0001);
    s4 = 4'b0100; cyc(); s4 = 4'b0000;
    ok = 1; k = 0;
    while (!(st4 === 3'd1 && ph4 === 2'd2) && k < 200) begin
      cyc();
      k++;
      if (g4[1] !== 1'b0) ok = 0;
    end
    chk("skip_phase", ph4, 2'd2);
    chk("skip_never1", ok, 1'b1);
    chk("skip_demand", u4.r_demand[2], 1'b0);

    repeat (120) begin
      s2 = 2'($urandom);
      s4 = 4'($urandom);
      f2 = ($urandom_range(0, 9) == 0);
      f4 = ($urandom_range(0, 9) == 0);
      rs2 = ($urandom_range(0, 39) == 0);
      rs4 = ($urandom_range(0, 39) == 0);
      repeat ($urandom_range(4, 40)) begin
        cyc();
        rs2 = 0;
        rs4 = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
